// File: rtl/fetch_stage.sv
// Instruction-fetch control: one outstanding imem request, IF/ID output register,
// next-PC selection (hold, +4, redirect) back to the PC register.
module fetch_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] PC_INC    = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_curr,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] req_addr_q, req_addr_d;

    logic aligned;
    logic req_fire;

    assign aligned        = (pc_curr[1:0] == 2'b00);
    assign imem_req_valid = (state_q == REQ) && aligned;
    assign imem_req_addr  = pc_curr;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d     = state_q;
        id_valid_d  = id_valid_q;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
        fetch_err_d = fetch_err_q;
        req_addr_d  = req_addr_q;
        pc_next     = pc_curr;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (!aligned) begin
                    fetch_err_d = 1'b1;
                end
                if (req_fire) begin
                    pc_next    = pc_curr + PC_INC;
                    req_addr_d = pc_curr;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    id_instr_d = imem_rsp_data;
                    id_pc_d    = req_addr_q;
                    id_valid_d = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (id_ready) begin
                    id_valid_d = 1'b0;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything except the post-reset settle cycle
        if (redirect_valid && state_q != IDLE) begin
            pc_next    = redirect_target;
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            id_pc_d    = id_pc_q;
            unique case (state_q)
                WAIT:    state_d = imem_rsp_valid ? REQ : DRAIN;
                REQ:     state_d = req_fire ? DRAIN : REQ;
                DRAIN:   state_d = imem_rsp_valid ? REQ : DRAIN;
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_valid_q  <= 1'b0;
            id_instr_q  <= NOP_INSTR;
            id_pc_q     <= 32'h0;
            fetch_err_q <= 1'b0;
            req_addr_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            fetch_err_q <= fetch_err_d;
            req_addr_q  <= req_addr_d;
        end
    end

    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: models the PC register and a
// variable-latency instruction memory returning addr + 0x1000_0000.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_curr;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_err;

    int n_chk = 0;
    int n_err = 0;

    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          rsp_delay;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_curr        (pc_curr),
        .pc_next        (pc_next),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .fetch_err      (fetch_err)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_curr <= 32'h0;
        else        pc_curr <= pc_next;
    end

    assign imem_rsp_valid = pend && (pend_cnt == 1);
    assign imem_rsp_data  = pend_addr + 32'h1000_0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            pend_cnt <= 0;
        end else if (imem_req_valid && imem_req_ready) begin
            pend      <= 1'b1;
            pend_addr <= imem_req_addr;
            pend_cnt  <= rsp_delay;
        end else if (pend) begin
            if (pend_cnt == 1) pend <= 1'b0;
            else               pend_cnt <= pend_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // want_id=1 waits for id_valid, else for imem_req_valid
    task automatic wait_for(input bit want_id, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(want_id ? id_valid : imem_req_valid) && n < 40);
        if (!(want_id ? id_valid : imem_req_valid))
            chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        bit saw;
        rst_n           = 1'b0;
        id_ready        = 1'b1;
        imem_req_ready  = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        rsp_delay       = 1;
        repeat (2) @(negedge clk);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_pc_next", pc_next, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);

        // sequential fetch 0x0, 0x4, 0x8
        for (int k = 0; k < 3; k++) begin
            wait_for(1'b0, "seq_req");
            chk("seq_addr", imem_req_addr, 32'(k * 4));
            chk("seq_pc_next", pc_next, 32'(k * 4 + 4));
            wait_for(1'b1, "seq_id");
            chk("seq_id_pc", id_pc, 32'(k * 4));
            chk("seq_id_instr", id_instr, 32'h1000_0000 + 32'(k * 4));
        end
        @(negedge clk);
        chk("seq_pulse", {31'd0, id_valid}, 32'd0);

        // decode stall in HOLD for instruction at 0xC
        id_ready = 1'b0;
        wait_for(1'b1, "hold_id");
        for (int i = 0; i < 5; i++) begin
            chk("hold_pc", id_pc, 32'h0000_000C);
            chk("hold_instr", id_instr, 32'h1000_000C);
            chk("hold_req", {31'd0, imem_req_valid}, 32'd0);
            chk("hold_pc_next", pc_next, pc_curr);
            @(negedge clk);
        end
        id_ready       = 1'b1;
        imem_req_ready = 1'b0;

        // memory not ready at 0x10
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("stall_addr", imem_req_addr, 32'h0000_0010);
            chk("stall_pc_next", pc_next, 32'h0000_0010);
        end
        imem_req_ready = 1'b1;
        #1;
        chk("stall_accept", pc_next, 32'h0000_0014);

        // redirect while waiting on 0x20
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_addr == 32'h20) break;
        end
        chk("rd_reach", imem_req_addr, 32'h0000_0020);
        rsp_delay = 3;
        @(negedge clk);
        rsp_delay       = 1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        #1;
        chk("rd_pc_next", pc_next, 32'h0000_0100);
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (id_valid) saw = 1'b1;
            if (imem_req_valid) break;
            @(negedge clk);
        end
        chk("rd_discard", {31'd0, saw}, 32'd0);
        chk("rd_new_addr", imem_req_addr, 32'h0000_0100);
        wait_for(1'b1, "rd_id");
        chk("rd_id_pc", id_pc, 32'h0000_0100);
        chk("rd_id_instr", id_instr, 32'h1000_0100);

        // misaligned redirect, then recovery
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0202;
        #1;
        chk("mis_pc_next", pc_next, 32'h0000_0202);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("mis_flush", {31'd0, id_valid}, 32'd0);
        chk("mis_req", {31'd0, imem_req_valid}, 32'd0);
        chk("mis_hold", pc_next, 32'h0000_0202);
        @(negedge clk);
        chk("mis_err", {31'd0, fetch_err}, 32'd1);
        chk("mis_req2", {31'd0, imem_req_valid}, 32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0300;
        #1;
        chk("rec_pc_next", pc_next, 32'h0000_0300);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("rec_req", {31'd0, imem_req_valid}, 32'd1);
        chk("rec_addr", imem_req_addr, 32'h0000_0300);
        chk("rec_err", {31'd0, fetch_err}, 32'd1);
        wait_for(1'b1, "rec_id");
        chk("rec_id_pc", id_pc, 32'h0000_0300);

        // PC wrap, then reset while waiting
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        rsp_delay       = 3;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_pc_next", pc_next, 32'h0000_0000);
        @(negedge clk);
        chk("wait_req", {31'd0, imem_req_valid}, 32'd0);
        chk("wait_pc", pc_curr, 32'h0000_0000);
        rst_n = 1'b0;
        #1;
        chk("arst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_id_instr", id_instr, 32'h0000_0013);
        chk("arst_id_pc", id_pc, 32'h0);
        chk("arst_req", {31'd0, imem_req_valid}, 32'd0);
        chk("arst_err", {31'd0, fetch_err}, 32'd0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch control stage between the program counter register and decode.
- Consumes pc_curr, issues one instruction-memory request at a time over a valid/ready handshake, and captures the response into an IF/ID output register with a valid/ready handshake to decode.
- Computes pc_next back to the PC register: hold, +4, or redirect target.

Parameters:
- NOP_INSTR, 32'h00000013, value held on id_instr at reset and after flush.
- PC_INC, 4, increment applied to pc_curr when a request is accepted.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_curr  input  32  current PC from the PC register.
- pc_next  output  32  next PC to the PC register (combinational).
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  instruction memory accepts request.
- imem_req_addr  output  32  fetch address; equals pc_curr.
- imem_rsp_valid  input  1  response valid, exactly one per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  fetched instruction word.
- id_valid  output  1  IF/ID register holds a valid instruction.
- id_ready  input  1  decode accepts the IF/ID contents.
- id_instr  output  32  registered instruction.
- id_pc  output  32  registered address of id_instr.
- redirect_valid  input  1  branch/jump/trap redirect, single-cycle pulse.
- redirect_target  input  32  redirect address.
- fetch_err  output  1  sticky misaligned-fetch flag.

Behaviour:
- Reset (async assert, sync release): state IDLE, id_valid=0, id_instr=NOP_INSTR, id_pc=0, fetch_err=0; imem_req_valid=0 and pc_next=pc_curr while in IDLE.
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN. IDLE→REQ unconditionally one cycle after reset release, so the PC register settles first.
- REQ:
  - imem_req_valid=1 only if pc_curr[1:0]==0.
  - If pc_curr[1:0]!=0: no request, fetch_err←1 (sticky until reset), stay REQ, pc_next=pc_curr. Only a redirect recovers.
  - On imem_req_valid&&imem_req_ready: pc_next=pc_curr+PC_INC (32-bit wrap: 0xFFFFFFFC→0x00000000), latch the request address internally, go WAIT.
  - Otherwise pc_next=pc_curr. imem_req_valid and imem_req_addr stay stable until accepted.
- WAIT: imem_req_valid=0, pc_next=pc_curr. On imem_rsp_valid: id_instr←imem_rsp_data, id_pc←latched address, id_valid←1, go HOLD.
- HOLD: id_valid=1 and id_* stable. On id_ready: id_valid←0, go REQ. Latency is 1 cycle from response to id_valid; throughput is at most one instruction per 3 cycles with zero-wait memory.
- Redirect (highest priority, any state except IDLE):
  - pc_next=redirect_target that cycle.
  - id_valid←0, id_instr←NOP_INSTR.
  - Next state:
    - WAIT without imem_rsp_valid → DRAIN.
    - WAIT with imem_rsp_valid in the same cycle → response discarded, go REQ.
    - REQ with request accepted in the same cycle → DRAIN, and pc_next is still redirect_target.
    - Otherwise → REQ.
  - In HOLD, a redirect coinciding with id_ready counts as consumed by decode; the IF/ID register still clears.
  - Redirect in IDLE is ignored.
- DRAIN: imem_req_valid=0, pc_next=pc_curr. The next imem_rsp_valid is discarded, then go REQ. A redirect during DRAIN updates pc_next and stays in DRAIN, unless the response arrives in the same cycle, in which case go REQ.
- At most one request is outstanding at any time; imem_rsp_valid outside WAIT/DRAIN is ignored.
- Reset asserted mid-operation: immediate return to reset values, any outstanding response is dropped, and memory is expected to be reset together with this block.

Test Plan:
- Reset, PC reset to 0x0, memory ready always with 1-cycle response → requests to 0x0, 0x4, 0x8; id_pc/id_instr match, id_valid pulses per instruction with id_ready=1.
- id_ready held low 5 cycles in HOLD → id_instr/id_pc stable, no new imem_req_valid, pc_next=pc_curr; release → state goes to REQ next cycle.
- imem_req_ready low 3 cycles at pc=0x10 → imem_req_valid held with addr 0x10, pc_next=0x10 until accept, then 0x14.
- Redirect to 0x100 while in WAIT for 0x20 → pc_next=0x100, the 0x20 response is discarded (id_valid stays 0), next request addr=0x100.
- Redirect to 0x202 → fetch_err=1, no request issued; redirect to 0x300 → fetch resumes at 0x300, fetch_err remains 1.
- pc_curr=0xFFFFFFFC accepted → pc_next=0x00000000; rst_n asserted during WAIT → id_valid=0, id_instr=0x00000013, imem_req_valid=0 immediately.
